// File: rtl/risc_debug_snapshot_ctrl_if.sv
// Debug snapshot bus: core write-back, frame/step controls in; display state out.
// Optional DBG_INSTR_COUNT_EN adds the instr_count signal.

interface risc_debug_snapshot_ctrl_if;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        frame_start;
    logic        run_sw;
    logic        step_btn;
    logic        cpu_en;
    logic [31:0] regs_demo [0:31];
    logic [31:0] changed_mask;
`ifdef DBG_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    modport master (
        output wb_en, wb_rd, wb_data,
        output frame_start, run_sw, step_btn,
        input  cpu_en, regs_demo, changed_mask
`ifdef DBG_INSTR_COUNT_EN
        , input instr_count
`endif
    );

    modport slave (
        input  wb_en, wb_rd, wb_data,
        input  frame_start, run_sw, step_btn,
        output cpu_en, regs_demo, changed_mask
`ifdef DBG_INSTR_COUNT_EN
        , output instr_count
`endif
    );
endinterface

// File: rtl/risc_debug_snapshot_ctrl.sv
// Register debug snapshot: frame-synchronous shadow regfile, change highlight,
// and free-run / debounced single-step core clock-enable sequencing.
// Ports: clock, reset_n (async active-low), bus (slave modport):
//   in  wb_en, wb_rd, wb_data, frame_start, run_sw, step_btn
//   out cpu_en, regs_demo[0:31], changed_mask, instr_count (DBG_INSTR_COUNT_EN)
// Macro DBG_INSTR_COUNT_EN: adds a 32-bit count of cpu_en cycles.

module risc_debug_snapshot_ctrl #(
    parameter int HOLD_FRAMES     = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    risc_debug_snapshot_ctrl_if.slave bus
);
    localparam logic [3:0]  HOLD = 4'(HOLD_FRAMES);
    localparam logic [19:0] DEB  = 20'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_WAIT_REL
    } state_t;

    // x0 is never stored: arrays start at index 1
    logic [31:0] regs_q [1:31];
    logic [31:0] pend   [1:31];
    logic [3:0]  age    [1:31];
    logic [31:1] pend_v;
    logic [31:1] mask_q;
    logic [31:1] hit;

    state_t      state_q, state_d;
    logic        cpu_en_c;
    logic        btn_prev, run_prev;
    logic [19:0] cnt_q;
    logic        stable_hi, stable_lo;

    always_comb begin
        hit = '0;
        for (int i = 1; i < 32; i++) begin
            hit[i] = bus.wb_en && (bus.wb_rd == 5'(i));
        end
    end

    // A write coinciding with frame_start is folded into that commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
                pend[i]   <= '0;
                age[i]    <= '0;
            end
            pend_v <= '0;
            mask_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (bus.frame_start) begin
                    if (pend_v[i] || hit[i]) begin
                        regs_q[i] <= hit[i] ? bus.wb_data : pend[i];
                        age[i]    <= HOLD;
                        mask_q[i] <= 1'b1;
                    end else if (age[i] != 4'd0) begin
                        age[i]    <= age[i] - 4'd1;
                        mask_q[i] <= (age[i] > 4'd1);
                    end
                    pend_v[i] <= 1'b0;
                end else if (hit[i]) begin
                    pend[i]   <= bus.wb_data;
                    pend_v[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.regs_demo[0] = '0;
    for (genvar g = 1; g < 32; g++) begin : g_regs
        assign bus.regs_demo[g] = regs_q[g];
    end
    assign bus.changed_mask = {mask_q, 1'b0};

    // cnt_q = consecutive cycles with step_btn and run_sw unchanged
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= 1'b0;
            run_prev <= 1'b0;
            cnt_q    <= '0;
        end else begin
            btn_prev <= bus.step_btn;
            run_prev <= bus.run_sw;
            if (bus.step_btn != btn_prev || bus.run_sw != run_prev)
                cnt_q <= '0;
            else if (cnt_q != '1)
                cnt_q <= cnt_q + 20'd1;
        end
    end

    assign stable_hi = (cnt_q >= DEB) && bus.step_btn && btn_prev;
    assign stable_lo = (cnt_q >= DEB) && !bus.step_btn && !btn_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_HALT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_c = 1'b0;
        unique case (state_q)
            S_RUN: begin
                cpu_en_c = 1'b1;
                if (!bus.run_sw) state_d = S_HALT;
            end
            S_HALT: begin
                if (bus.run_sw)     state_d = S_RUN;
                else if (stable_hi) state_d = S_STEP;
            end
            S_STEP: begin
                cpu_en_c = 1'b1;
                state_d  = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (bus.run_sw)     state_d = S_RUN;
                else if (stable_lo) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign bus.cpu_en = cpu_en_c;

`ifdef DBG_INSTR_COUNT_EN
    logic [31:0] icnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      icnt_q <= '0;
        else if (cpu_en_c) icnt_q <= icnt_q + 32'd1;
    end

    assign bus.instr_count = icnt_q;
`endif
endmodule

// File: tb/tb_risc_debug_snapshot_ctrl.sv
// Scoreboard bench for risc_debug_snapshot_ctrl: directed + random stimulus
// against a behavioural model; monitor checks every clocked output.

module tb_risc_debug_snapshot_ctrl;
    localparam int HOLD = 3;
    localparam int DEB  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    risc_debug_snapshot_ctrl_if bus();

    risc_debug_snapshot_ctrl #(
        .HOLD_FRAMES(HOLD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic          cpu;
        logic [31:0]   mask;
        logic [1023:0] regs;
        logic [31:0]   icnt;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    bit [31:0] m_regs [32];
    bit [31:0] m_pend [32];
    bit        m_pv   [32];
    int        m_age  [32];
    bit        m_running, m_armed, m_pulse;
    bit        m_btn_prev, m_run_prev;
    int        m_same;
    bit [31:0] m_icnt;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = '0;
            m_pv[i]   = 1'b0;
            m_age[i]  = 0;
        end
        m_running  = 1'b0;
        m_armed    = 1'b1;
        m_pulse    = 1'b0;
        m_btn_prev = 1'b0;
        m_run_prev = 1'b0;
        m_same     = 0;
        m_icnt     = '0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        bit stable;
        bit hit;
        if (m_running || m_pulse) m_icnt = m_icnt + 32'd1;
        if (bus.frame_start) begin
            for (int i = 1; i < 32; i++) begin
                hit = bus.wb_en && (bus.wb_rd == 5'(i));
                if (m_pv[i] || hit) begin
                    m_regs[i] = hit ? bus.wb_data : m_pend[i];
                    m_age[i]  = HOLD;
                end else if (m_age[i] > 0) begin
                    m_age[i] = m_age[i] - 1;
                end
                m_pv[i] = 1'b0;
            end
        end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
            m_pend[bus.wb_rd] = bus.wb_data;
            m_pv[bus.wb_rd]   = 1'b1;
        end
        stable = (m_same >= DEB) && (bus.step_btn == m_btn_prev);
        if (m_running) begin
            if (!bus.run_sw) begin
                m_running = 1'b0;
                m_armed   = 1'b1;
            end
        end else if (m_pulse) begin
            m_pulse = 1'b0;
            m_armed = 1'b0;
        end else if (bus.run_sw) begin
            m_running = 1'b1;
        end else if (m_armed) begin
            if (stable && bus.step_btn) m_pulse = 1'b1;
        end else if (stable && !bus.step_btn) begin
            m_armed = 1'b1;
        end
        if (bus.step_btn != m_btn_prev || bus.run_sw != m_run_prev)
            m_same = 0;
        else
            m_same = m_same + 1;
        m_btn_prev = bus.step_btn;
        m_run_prev = bus.run_sw;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.cpu  = m_running || m_pulse;
        e.icnt = m_icnt;
        for (int i = 0; i < 32; i++) begin
            e.mask[i]         = (m_age[i] != 0);
            e.regs[i*32 +: 32] = m_regs[i];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        logic [1023:0] act;
        for (int i = 0; i < 32; i++) act[i*32 +: 32] = bus.regs_demo[i];
        chk("cpu_en", {31'b0, bus.cpu_en}, {31'b0, e.cpu});
        chk("changed_mask", bus.changed_mask, e.mask);
        n_cmp++;
        if (act !== e.regs) begin
            n_bad++;
            for (int i = 0; i < 32; i++) begin
                if (act[i*32 +: 32] !== e.regs[i*32 +: 32]) begin
                    $display("FAIL regs_demo[%0d]: got %h expected %h at %0t",
                             i, act[i*32 +: 32], e.regs[i*32 +: 32], $time);
                    break;
                end
            end
        end
`ifdef DBG_INSTR_COUNT_EN
        chk("instr_count", bus.instr_count, e.icnt);
`endif
    endtask

    task automatic drive(input bit en, input logic [4:0] rd,
                         input logic [31:0] d, input bit fs,
                         input bit run, input bit btn);
        @(negedge clk);
        bus.wb_en       = en;
        bus.wb_rd       = rd;
        bus.wb_data     = d;
        bus.frame_start = fs;
        bus.run_sw      = run;
        bus.step_btn    = btn;
        model_edge();
        sbq.push_back(model_out());
    endtask

    task automatic idle_inputs();
        bus.wb_en       = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.frame_start = 1'b0;
        bus.run_sw      = 1'b0;
        bus.step_btn    = 1'b0;
    endtask

    // The edge right after release sees idle inputs; model it too
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_edge();
        sbq.push_back(model_out());
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                compare_all(e);
            end
        end
    end

    initial begin
        bit btn = 1'b0;
        bit run = 1'b0;
        int btn_left = 0;
        int run_left = 200;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all(model_out());
        repeat (2) @(negedge clk);
        release_reset();
        repeat (3) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // x5 commit, then highlight ageing over three frames
        drive(1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        // last write wins, x0 ignored
        drive(1'b1, 5'd7, 32'hA, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd7, 32'hB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // write forwarded into same-cycle commit
        drive(1'b1, 5'd3, 32'h55, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // bounce then hold, release, second press
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (40) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // free run
        repeat (100) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if (btn_left == 0) begin
                btn      = ~btn;
                btn_left = int'($urandom_range(1, 20));
            end
            btn_left--;
            if (run_left == 0) begin
                run      = ~run;
                run_left = run ? int'($urandom_range(5, 30))
                               : int'($urandom_range(100, 400));
            end
            run_left--;
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 9) == 0, run, btn);
        end

        // mid-run reset with writes still pending
        repeat (5) drive(1'b1, 5'($urandom_range(1, 31)), $urandom,
                         1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        compare_all(model_out());
        release_reset();
        repeat (3) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 200; n++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 5) == 0, n > 150, 1'b0);
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
